// File: rtl/pipelined_dp_ram.sv
// Dual-port byte-enabled RAM that clears itself after reset. Reads return 2 cycles after acceptance, one per cycle per port.
// Ready drops only in INIT, or for the losing port of a same-address write/write collision; valid and data have no backpressure.
module pipelined_dp_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int RD_MODE    = 0,
  parameter int A_PRIORITY = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    a_req_in,
  input  logic                    a_we_in,
  input  logic [DATA_WIDTH/8-1:0] a_be_in,
  input  logic [ADDR_WIDTH-1:0]   a_addr_in,
  input  logic [DATA_WIDTH-1:0]   a_data_in,
  output logic                    a_ready_out,
  output logic [DATA_WIDTH-1:0]   a_data_out,
  output logic                    a_valid_out,
  input  logic                    b_req_in,
  input  logic                    b_we_in,
  input  logic [DATA_WIDTH/8-1:0] b_be_in,
  input  logic [ADDR_WIDTH-1:0]   b_addr_in,
  input  logic [DATA_WIDTH-1:0]   b_data_in,
  output logic                    b_ready_out,
  output logic [DATA_WIDTH-1:0]   b_data_out,
  output logic                    b_valid_out,
  output logic                    init_done_out,
  output logic [15:0]             collision_cnt_out
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   init_cnt, init_cnt_nxt;
  logic                    run;
  logic                    collision;
  logic                    a_wr, a_rd, b_wr, b_rd;
  logic [DATA_WIDTH-1:0]   a_rd_word, b_rd_word;
  logic                    a_s1_vld, a_s2_vld, b_s1_vld, b_s2_vld;
  logic [DATA_WIDTH-1:0]   a_s1_dat, a_s2_dat, b_s1_dat, b_s2_dat;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] old_w,
                                                  input logic [DATA_WIDTH-1:0] new_w,
                                                  input logic [NB-1:0]         be);
    logic [DATA_WIDTH-1:0] res;
    res = old_w;
    for (int i = 0; i < NB; i++)
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    return res;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end else begin
      state    <= state_nxt;
      init_cnt <= init_cnt_nxt;
    end
  end

  // RUN is entered on the same edge that clears the last address.
  always_comb begin
    state_nxt     = state;
    init_cnt_nxt  = init_cnt;
    run           = 1'b0;
    init_done_out = 1'b0;
    case (state)
      ST_INIT: begin
        init_cnt_nxt = init_cnt + ADDR_WIDTH'(1);
        if (&init_cnt) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        run           = 1'b1;
        init_done_out = 1'b1;
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  assign collision   = run & a_req_in & b_req_in & a_we_in & b_we_in & (a_addr_in == b_addr_in);
  assign a_ready_out = run & ~(collision & (A_PRIORITY == 0));
  assign b_ready_out = run & ~(collision & (A_PRIORITY != 0));

  assign a_wr = a_req_in & a_ready_out & a_we_in;
  assign a_rd = a_req_in & a_ready_out & ~a_we_in;
  assign b_wr = b_req_in & b_ready_out & b_we_in;
  assign b_rd = b_req_in & b_ready_out & ~b_we_in;

  always_ff @(posedge clock) begin
    if (!run) begin
      mem[init_cnt] <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (a_wr && a_be_in[i]) mem[a_addr_in][8*i +: 8] <= a_data_in[8*i +: 8];
        if (b_wr && b_be_in[i]) mem[b_addr_in][8*i +: 8] <= b_data_in[8*i +: 8];
      end
    end
  end

  // Write-first forwards the other port's same-cycle write into the read word.
  always_comb begin
    a_rd_word = mem[a_addr_in];
    b_rd_word = mem[b_addr_in];
    if (RD_MODE == 1) begin
      if (b_wr && (b_addr_in == a_addr_in)) a_rd_word = merge(a_rd_word, b_data_in, b_be_in);
      if (a_wr && (a_addr_in == b_addr_in)) b_rd_word = merge(b_rd_word, a_data_in, a_be_in);
    end
  end

  always_ff @(posedge clock) begin
    if (a_rd) a_s1_dat <= a_rd_word;
    if (b_rd) b_s1_dat <= b_rd_word;
    a_s2_dat <= a_s1_dat;
    b_s2_dat <= b_s1_dat;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      a_s1_vld    <= 1'b0;
      a_s2_vld    <= 1'b0;
      a_valid_out <= 1'b0;
      a_data_out  <= '0;
      b_s1_vld    <= 1'b0;
      b_s2_vld    <= 1'b0;
      b_valid_out <= 1'b0;
      b_data_out  <= '0;
    end else begin
      a_s1_vld    <= a_rd;
      a_s2_vld    <= a_s1_vld;
      a_valid_out <= a_s2_vld;
      if (a_s2_vld) a_data_out <= a_s2_dat;
      b_s1_vld    <= b_rd;
      b_s2_vld    <= b_s1_vld;
      b_valid_out <= b_s2_vld;
      if (b_s2_vld) b_data_out <= b_s2_dat;
    end
  end

  always_ff @(posedge clock) begin
    if (reset)
      collision_cnt_out <= '0;
    else if (collision && (collision_cnt_out != 16'hFFFF))
      collision_cnt_out <= collision_cnt_out + 16'd1;
  end

endmodule

// File: tb/tb_pipelined_dp_ram.sv
// Directed bench: two instances sharing stimulus, read-first (dut0) and write-first (dut1), both with a 16-word array.
module tb_pipelined_dp_ram;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_req, a_we, b_req, b_we;
  logic [3:0]  a_be, b_be, a_addr, b_addr;
  logic [31:0] a_dat, b_dat;

  logic        a_rdy0, b_rdy0, a_vld0, b_vld0, done0;
  logic        a_rdy1, b_rdy1, a_vld1, b_vld1, done1;
  logic [31:0] a_q0, b_q0, a_q1, b_q1;
  logic [15:0] coll0, coll1;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  pipelined_dp_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .RD_MODE(0), .A_PRIORITY(1)) dut0 (
    .clock(clk), .reset(reset),
    .a_req_in(a_req), .a_we_in(a_we), .a_be_in(a_be), .a_addr_in(a_addr), .a_data_in(a_dat),
    .a_ready_out(a_rdy0), .a_data_out(a_q0), .a_valid_out(a_vld0),
    .b_req_in(b_req), .b_we_in(b_we), .b_be_in(b_be), .b_addr_in(b_addr), .b_data_in(b_dat),
    .b_ready_out(b_rdy0), .b_data_out(b_q0), .b_valid_out(b_vld0),
    .init_done_out(done0), .collision_cnt_out(coll0));

  pipelined_dp_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .RD_MODE(1), .A_PRIORITY(1)) dut1 (
    .clock(clk), .reset(reset),
    .a_req_in(a_req), .a_we_in(a_we), .a_be_in(a_be), .a_addr_in(a_addr), .a_data_in(a_dat),
    .a_ready_out(a_rdy1), .a_data_out(a_q1), .a_valid_out(a_vld1),
    .b_req_in(b_req), .b_we_in(b_we), .b_be_in(b_be), .b_addr_in(b_addr), .b_data_in(b_dat),
    .b_ready_out(b_rdy1), .b_data_out(b_q1), .b_valid_out(b_vld1),
    .init_done_out(done1), .collision_cnt_out(coll1));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_req = 1'b0;
    b_req = 1'b0;
  endtask

  task automatic wr(input logic port_b, input logic [3:0] addr, input logic [31:0] d, input logic [3:0] be);
    if (!port_b) begin
      a_req = 1'b1; a_we = 1'b1; a_addr = addr; a_dat = d; a_be = be;
    end else begin
      b_req = 1'b1; b_we = 1'b1; b_addr = addr; b_dat = d; b_be = be;
    end
    tick();
    idle();
  endtask

  // Accepting edge, then valid must be low after +1 and high after +2, then low again with data held.
  task automatic rd_chk(input logic port_b, input logic [3:0] addr, input logic [31:0] e0,
                        input logic [31:0] e1, input string tag);
    if (!port_b) begin
      a_req = 1'b1; a_we = 1'b0; a_addr = addr;
    end else begin
      b_req = 1'b1; b_we = 1'b0; b_addr = addr;
    end
    tick();
    idle();
    tick();
    chk({tag, "_v_early"}, port_b ? b_vld0 : a_vld0, 0);
    tick();
    chk({tag, "_v0"}, port_b ? b_vld0 : a_vld0, 1);
    chk({tag, "_v1"}, port_b ? b_vld1 : a_vld1, 1);
    chk({tag, "_d0"}, port_b ? b_q0 : a_q0, e0);
    chk({tag, "_d1"}, port_b ? b_q1 : a_q1, e1);
    tick();
    chk({tag, "_v_late"}, port_b ? b_vld0 : a_vld0, 0);
    chk({tag, "_hold"}, port_b ? b_q0 : a_q0, e0);
  endtask

  // Counts edges until init completes, flagging any valid seen on the way.
  task automatic wait_init(input string tag, input int exp_cycles);
    int n;
    int vlds;
    n = 0;
    vlds = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      vlds += int'(a_vld0) + int'(b_vld0) + int'(a_vld1) + int'(b_vld1);
      if (done0 && done1) begin
        n = i;
        break;
      end
      chk({tag, "_rdy_init"}, {31'd0, a_rdy0 | b_rdy0}, 0);
    end
    idle();
    chk({tag, "_init_cycles"}, n, exp_cycles);
    chk({tag, "_no_valid"}, vlds, 0);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    a_we = 1'b0; b_we = 1'b0; a_be = 4'h0; b_be = 4'h0;
    a_addr = 4'h0; b_addr = 4'h0; a_dat = 32'h0; b_dat = 32'h0;
    tick();
    tick();
    chk("rst_done", {31'd0, done0}, 0);
    chk("rst_valid", {31'd0, a_vld0 | b_vld0 | a_vld1 | b_vld1}, 0);
    chk("rst_data", a_q0 | b_q0, 0);
    chk("rst_coll", {16'd0, coll0}, 0);
    chk("rst_ready", {31'd0, a_rdy0 | b_rdy0}, 0);

    // A read held throughout INIT must be dropped, not queued.
    reset = 1'b0;
    a_req = 1'b1; a_we = 1'b0; a_addr = 4'd5;
    wait_init("init1", 16);
    rd_chk(1'b0, 4'd5, 32'h0, 32'h0, "rd5_zero");

    wr(1'b0, 4'd3, 32'hDEADBEEF, 4'b1111);
    wr(1'b1, 4'd3, 32'h000000AA, 4'b0001);
    rd_chk(1'b0, 4'd3, 32'hDEADBEAA, 32'hDEADBEAA, "be_merge");
    wr(1'b0, 4'd3, 32'h12345678, 4'b0000);
    rd_chk(1'b1, 4'd3, 32'hDEADBEAA, 32'hDEADBEAA, "be_noop");

    // Write/write collision on address 7 with B holding its request.
    a_req = 1'b1; a_we = 1'b1; a_addr = 4'd7; a_dat = 32'd11; a_be = 4'hF;
    b_req = 1'b1; b_we = 1'b1; b_addr = 4'd7; b_dat = 32'd22; b_be = 4'hF;
    #1;
    chk("coll_a_rdy", {31'd0, a_rdy0}, 1);
    chk("coll_b_rdy", {31'd0, b_rdy0}, 0);
    tick();
    a_req = 1'b0;
    #1;
    chk("coll_b_rdy_next", {31'd0, b_rdy0}, 1);
    tick();
    idle();
    chk("coll_cnt0", {16'd0, coll0}, 1);
    chk("coll_cnt1", {16'd0, coll1}, 1);
    rd_chk(1'b0, 4'd7, 32'd22, 32'd22, "coll_final");

    // Same-cycle same-address write on A and read on B.
    wr(1'b0, 4'd9, 32'd5, 4'hF);
    a_req = 1'b1; a_we = 1'b1; a_addr = 4'd9; a_dat = 32'd6; a_be = 4'hF;
    b_req = 1'b1; b_we = 1'b0; b_addr = 4'd9;
    tick();
    idle();
    tick();
    tick();
    chk("rw_vld", {31'd0, b_vld0 & b_vld1}, 1);
    chk("rw_rdfirst", b_q0, 32'd5);
    chk("rw_wrfirst", b_q1, 32'd6);

    // Partial-byte write on B while A reads the same word.
    wr(1'b0, 4'd10, 32'hAABBCCDD, 4'hF);
    b_req = 1'b1; b_we = 1'b1; b_addr = 4'd10; b_dat = 32'h00000011; b_be = 4'b0001;
    a_req = 1'b1; a_we = 1'b0; a_addr = 4'd10;
    tick();
    idle();
    tick();
    tick();
    chk("rwp_rdfirst", a_q0, 32'hAABBCCDD);
    chk("rwp_wrfirst", a_q1, 32'hAABBCC11);

    // Read/read same address.
    a_req = 1'b1; a_we = 1'b0; a_addr = 4'd3;
    b_req = 1'b1; b_we = 1'b0; b_addr = 4'd3;
    #1;
    chk("rr_rdy", {31'd0, a_rdy0 & b_rdy0}, 1);
    tick();
    idle();
    tick();
    tick();
    chk("rr_vld", {31'd0, a_vld0 & b_vld0}, 1);
    chk("rr_a", a_q0, 32'hDEADBEAA);
    chk("rr_b", b_q0, 32'hDEADBEAA);

    // Simultaneous writes to different addresses.
    a_req = 1'b1; a_we = 1'b1; a_addr = 4'd12; a_dat = 32'h12345678; a_be = 4'hF;
    b_req = 1'b1; b_we = 1'b1; b_addr = 4'd13; b_dat = 32'h9ABCDEF0; b_be = 4'hF;
    tick();
    idle();
    chk("ww_coll", {16'd0, coll0}, 1);
    rd_chk(1'b0, 4'd12, 32'h12345678, 32'h12345678, "ww_a");
    rd_chk(1'b1, 4'd13, 32'h9ABCDEF0, 32'h9ABCDEF0, "ww_b");

    // Back-to-back reads of 0..7.
    for (int i = 0; i < 8; i++) wr(1'b1, 4'(i), 32'h100 + i, 4'hF);
    for (int i = 0; i < 10; i++) begin
      a_req = (i < 8); a_we = 1'b0; a_addr = 4'(i);
      tick();
      if (i >= 2) begin
        chk($sformatf("b2b_v%0d", i - 2), {31'd0, a_vld0}, 1);
        chk($sformatf("b2b_d%0d", i - 2), a_q0, 32'h100 + i - 2);
      end else begin
        chk($sformatf("b2b_pre%0d", i), {31'd0, a_vld0}, 0);
      end
    end
    idle();
    tick();
    chk("b2b_end", {31'd0, a_vld0}, 0);

    // Reset with two reads in flight.
    a_req = 1'b1; a_we = 1'b0; a_addr = 4'd1;
    tick();
    a_addr = 4'd2;
    tick();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst2_valid", {31'd0, a_vld0 | a_vld1}, 0);
    chk("rst2_coll", {16'd0, coll0}, 0);
    chk("rst2_done", {31'd0, done0}, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rst2_no_valid", {31'd0, a_vld0 | a_vld1}, 0);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_init("init2", 16);
    rd_chk(1'b0, 4'd1, 32'h0, 32'h0, "clr1");
    rd_chk(1'b1, 4'd3, 32'h0, 32'h0, "clr3");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/pipelined_dp_ram.md
PIPELINED_DP_RAM -- requirements
Module: pipelined_dp_ram

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, word width in bits; it SHALL be a multiple of 8.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 10, giving a depth of 2^ADDR_WIDTH words.
REQ-003 The block SHALL have parameter RD_MODE, default 0: 0 = read-first, 1 = write-first on same-address read/write.
REQ-004 The block SHALL have parameter A_PRIORITY, default 1: 1 = port A wins write/write collisions, 0 = port B wins.
REQ-005 The block SHALL have port clock, input, 1, the single clock; all logic is rising-edge.
REQ-006 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 The block SHALL have, for each port x in {a,b}, port x_req_in, input, 1, access request.
REQ-008 The block SHALL have port x_we_in, input, 1: 1 = write, 0 = read.
REQ-009 The block SHALL have port x_be_in, input, DATA_WIDTH/8, byte write enables.
REQ-010 The block SHALL have port x_addr_in, input, ADDR_WIDTH, word address.
REQ-011 The block SHALL have port x_data_in, input, DATA_WIDTH, write data.
REQ-012 The block SHALL have port x_ready_out, output, 1, request accepted this cycle.
REQ-013 The block SHALL have port x_data_out, output, DATA_WIDTH, read data.
REQ-014 The block SHALL have port x_valid_out, output, 1, x_data_out valid for one cycle.
REQ-015 The block SHALL have port init_done_out, output, 1, high once memory clearing is complete.
REQ-016 The block SHALL have port collision_cnt_out, output, 16, saturating count of write/write collisions.

Function
REQ-017 The block SHALL use a two-state machine: INIT, which clears memory, and RUN, which serves requests.
REQ-018 In INIT, an internal counter SHALL write all-zero to address 0..2^ADDR_WIDTH-1, one word per cycle; after the last address the block SHALL enter RUN on the next edge.
REQ-019 In INIT, a_ready_out, b_ready_out and init_done_out SHALL be 0, and requests SHALL be ignored, not queued.
REQ-020 In RUN, init_done_out SHALL be 1.
REQ-021 x_ready_out SHALL be combinational, and 1 in RUN except for the collision loser (REQ-025).
REQ-022 A transfer SHALL occur on x_req_in & x_ready_out at a rising edge.
REQ-023 On a write transfer, only the bytes with x_be_in[i]=1 SHALL update; x_be_in = 0 is a legal no-op write and SHALL produce no valid.
REQ-024 On a read transfer, x_valid_out SHALL pulse exactly 2 cycles after the accepting edge (array read stage plus output register), carrying data from that read; reads SHALL be fully pipelined, one per cycle per port.
REQ-025 A write/write collision is both ports requesting a write to the same address in the same cycle; the priority port SHALL be accepted, the other port's ready SHALL be 0 that cycle, and collision_cnt_out SHALL increment, saturating at 16'hFFFF.
REQ-026 A collision loser that keeps x_req_in high SHALL be accepted on the next cycle without a further collision, unless the collision recurs.
REQ-027 On a same-cycle same-address read and write, with RD_MODE=0 the read SHALL return the pre-write word; with RD_MODE=1 it SHALL return the byte-merged new word.
REQ-028 Read/read to the same address SHALL both be accepted and return identical data.
REQ-029 Writes to different addresses on both ports in the same cycle SHALL both complete.
REQ-030 x_data_out SHALL hold its last valid value while x_valid_out = 0.

Reset
REQ-031 When reset=1 at an edge, the block SHALL enter INIT with the counter at 0.
REQ-032 When reset=1 at an edge, x_valid_out, x_data_out and collision_cnt_out SHALL be 0 and init_done_out SHALL be 0.
REQ-033 Reset mid-RUN SHALL discard in-flight reads, so no valid is emitted for them, and SHALL re-clear the whole array.
REQ-034 Reset asserted during INIT SHALL restart clearing from address 0.

Verification
REQ-035 Reset for 1 cycle, then idle, with ADDR_WIDTH=4: init_done_out SHALL rise exactly 16 cycles after reset deasserts, and a read of address 5 SHALL return 0.
REQ-036 A writes 32'hDEADBEEF with be=4'b1111 to address 3, then B writes 32'h000000AA with be=4'b0001 to address 3, then A reads address 3: the read SHALL return 32'hDEADBEAA with valid 2 cycles after acceptance.
REQ-037 With A_PRIORITY=1, A and B write address 7 simultaneously (11 and 22), B holding req: b_ready_out SHALL be 0 for 1 cycle, the final word SHALL be 22, and collision_cnt_out SHALL be 1.
REQ-038 Address 9 holds 5; A writes 6 while B reads address 9 in the same cycle: B SHALL get 5 with RD_MODE=0 and 6 with RD_MODE=1.
REQ-039 Back-to-back reads of addresses 0..7 on port A: 8 consecutive valid pulses SHALL occur, in order, starting at cycle +2.
REQ-040 Reset asserted with 2 reads in flight: no valid SHALL appear, collision_cnt_out SHALL be 0, and init SHALL restart.
